// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with per-register pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                re,
  input  logic [NRD*$clog2(NREG)-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                claim,
  input  logic [$clog2(NREG)-1:0] caddr,
  output logic [NRD-1:0]      rbusy
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs   [NREG];
  logic [XLEN-1:0] rd_val [NRD];
  logic [NREG-1:0] busy;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0] ra;
    assign ra = raddr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit       = re && we && (waddr == ra) && (ra != '0);
    assign rd_val[g] = hit ? wdata : regs[ra];
    // A same-cycle write resolves the pending state unless a newer claim retakes it.
    assign rbusy[g]  = busy[ra] && (ra != '0) && !(hit && !(claim && (caddr == ra)));
`else
    assign rd_val[g] = regs[ra];
    assign rbusy[g]  = busy[ra] && (ra != '0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy  <= '0;
      rdata <= '0;
    end else begin
      if (we && (waddr != '0)) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      // Placed after the write clear so a coincident claim keeps the bit set.
      if (claim && (caddr != '0)) busy[caddr] <= 1'b1;
      if (re) begin
        for (int i = 0; i < NRD; i++) rdata[i*XLEN +: XLEN] <= rd_val[i];
      end
    end
  end
endmodule
